// File: rtl/sva_rep_matcher_if.sv
// sva_rep_matcher_if: attempt handshake and result bus (stats counters with SVA_REP_MATCHER_STATS_EN)
interface sva_rep_matcher_if;
    logic       start;
    logic       a;
    logic       b;
    logic       match;
    logic       fail;
    logic       busy;
    logic [3:0] rep_count;
`ifdef SVA_REP_MATCHER_STATS_EN
    logic [15:0] match_cnt;
    logic [15:0] fail_cnt;
    modport master (output start, a, b, input match, fail, busy, rep_count, match_cnt, fail_cnt);
    modport slave  (input start, a, b, output match, fail, busy, rep_count, match_cnt, fail_cnt);
`else
    modport master (output start, a, b, input match, fail, busy, rep_count);
    modport slave  (input start, a, b, output match, fail, busy, rep_count);
`endif
endinterface

// File: rtl/sva_rep_matcher.sv
// sva_rep_matcher: a[*MIN_REP:MAX_REP] ##DELAY b recognizer; SVA_REP_MATCHER_STATS_EN adds match/fail counters
module sva_rep_matcher #(
    parameter int MIN_REP = 0,
    parameter int MAX_REP = 3,
    parameter int DELAY   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    sva_rep_matcher_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [5:0] MIN_V = 6'(MIN_REP);
    localparam logic [5:0] MAX_V = 6'(MAX_REP);
    state_t     state_q, state_d;
    logic [3:0] rep_q, rep_d;
    logic       match_q, match_d, fail_q, fail_d;
    logic       eval, hit, cont;
    logic [5:0] n, n1;
    // evaluate the attempt cycle: match first, otherwise extend the repetition or give up
    always_comb begin
        eval    = (state_q == RUN) || bus.start;
        n       = (state_q == RUN) ? {2'b00, rep_q} : 6'd0;
        n1      = n + 6'd1;
        hit     = (DELAY == 0) ? (bus.a && bus.b && (n1 + 6'd1) > MIN_V && n1 <= MAX_V)
                               : (bus.b && n1 > MIN_V && n <= MAX_V);
        cont    = bus.a && ((DELAY == 0) ? (n1 < MAX_V) : (n1 <= MAX_V));
        state_d = state_q;
        rep_d   = rep_q;
        match_d = 1'b0;
        fail_d  = 1'b0;
        if (eval) begin
            state_d = (!hit && cont) ? RUN : IDLE;
            rep_d   = (!hit && cont) ? n1[3:0] : n[3:0];
            match_d = hit;
            fail_d  = !hit && !cont;
        end
    end
    // state, repetition count and registered result pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rep_q   <= 4'd0;
            match_q <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            match_q <= match_d;
            fail_q  <= fail_d;
        end
    end
    assign bus.match     = match_q;
    assign bus.fail      = fail_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.rep_count = rep_q;
`ifdef SVA_REP_MATCHER_STATS_EN
    logic [15:0] match_cnt_q, fail_cnt_q;
    // saturating counters advance together with the result pulse they count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match_cnt_q <= 16'd0;
            fail_cnt_q  <= 16'd0;
        end else begin
            if (match_d && match_cnt_q != 16'hFFFF) match_cnt_q <= match_cnt_q + 16'd1;
            if (fail_d && fail_cnt_q != 16'hFFFF) fail_cnt_q <= fail_cnt_q + 16'd1;
        end
    end
    assign bus.match_cnt = match_cnt_q;
    assign bus.fail_cnt  = fail_cnt_q;
`endif
endmodule

// File: tb/tb_sva_rep_matcher.sv
// tb_sva_rep_matcher: four parameterisations driven in lockstep and checked against a behavioural model
module tb_sva_rep_matcher;
    logic clk = 1'b0;
    logic rn = 1'b0, st = 1'b0, av = 1'b0, bv = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] om, of, ob;
    logic [3:0] orc [4];
    int n_cmp = 0, n_err = 0;
    int mn [4] = '{0, 0, 2, 1};
    int mx [4] = '{3, 3, 3, 2};
    int dl [4] = '{1, 0, 1, 1};
    bit m_run [4];
    int m_n [4];
    bit m_match [4];
    bit m_fail [4];
`ifdef SVA_REP_MATCHER_STATS_EN
    logic [15:0] omc [4];
    logic [15:0] ofc [4];
    int m_mc [4];
    int m_fc [4];
`endif

    sva_rep_matcher_if ifs [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sva_rep_matcher #(
            .MIN_REP(g == 2 ? 2 : (g == 3 ? 1 : 0)),
            .MAX_REP(g == 3 ? 2 : 3),
            .DELAY  (g == 1 ? 0 : 1)
        ) u_dut (
            .clk  (clk),
            .rst_n(rn),
            .bus  (ifs[g])
        );
        assign ifs[g].start = st;
        assign ifs[g].a     = av;
        assign ifs[g].b     = bv;
        assign om[g]        = ifs[g].match;
        assign of[g]        = ifs[g].fail;
        assign ob[g]        = ifs[g].busy;
        assign orc[g]       = ifs[g].rep_count;
`ifdef SVA_REP_MATCHER_STATS_EN
        assign omc[g]       = ifs[g].match_cnt;
        assign ofc[g]       = ifs[g].fail_cnt;
`endif
    end

    task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    function automatic void model_step();
        for (int k = 0; k < 4; k++) begin
            int n, reps;
            bit closes;
            if (!rn) begin
                m_run[k] = 0; m_n[k] = 0; m_match[k] = 0; m_fail[k] = 0;
`ifdef SVA_REP_MATCHER_STATS_EN
                m_mc[k] = 0; m_fc[k] = 0;
`endif
            end else begin
                m_match[k] = 0;
                m_fail[k]  = 0;
                if (m_run[k] || st) begin
                    n      = m_run[k] ? m_n[k] : 0;
                    reps   = (dl[k] == 1) ? n : n + 1;
                    closes = (dl[k] == 1) ? bv : (av && bv);
                    if (closes && reps >= mn[k] && reps <= mx[k]) begin
                        m_match[k] = 1; m_run[k] = 0; m_n[k] = n;
                    end else if (av && n + 1 + (1 - dl[k]) <= mx[k]) begin
                        m_run[k] = 1; m_n[k] = n + 1;
                    end else begin
                        m_fail[k] = 1; m_run[k] = 0; m_n[k] = n;
                    end
                end
`ifdef SVA_REP_MATCHER_STATS_EN
                if (m_match[k] && m_mc[k] < 65535) m_mc[k]++;
                if (m_fail[k] && m_fc[k] < 65535) m_fc[k]++;
`endif
            end
        end
    endfunction

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            chk("match", k, 16'(om[k]), 16'(m_match[k]));
            chk("fail", k, 16'(of[k]), 16'(m_fail[k]));
            chk("busy", k, 16'(ob[k]), 16'(m_run[k]));
            chk("rep_count", k, 16'(orc[k]), 16'(m_n[k]));
`ifdef SVA_REP_MATCHER_STATS_EN
            chk("match_cnt", k, omc[k], 16'(m_mc[k]));
            chk("fail_cnt", k, ofc[k], 16'(m_fc[k]));
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        rn = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 4; k++) begin
            chk("rst_busy", k, 16'(ob[k]), 16'd0);
            chk("rst_rep", k, 16'(orc[k]), 16'd0);
        end
        rn = 1'b1;
        st = 1'b1; bv = 1'b1;
        tick();
        st = 1'b0; bv = 1'b0;
        chk("empty_match", 0, 16'(om[0]), 16'd1);
        chk("empty_busy", 0, 16'(ob[0]), 16'd0);
        chk("empty_d0_fail", 1, 16'(of[1]), 16'd1);
        chk("empty_d0_nomatch", 1, 16'(om[1]), 16'd0);
        repeat (2) tick();
        st = 1'b1; av = 1'b1;
        tick();
        st = 1'b0;
        tick();
        chk("rep2_count", 2, 16'(orc[2]), 16'd2);
        av = 1'b0; bv = 1'b1;
        tick();
        bv = 1'b0;
        chk("rep2_match", 2, 16'(om[2]), 16'd1);
        repeat (2) tick();
        st = 1'b1; av = 1'b1;
        tick();
        st = 1'b0;
        repeat (2) tick();
        av = 1'b0;
        chk("overmax_fail", 3, 16'(of[3]), 16'd1);
        repeat (2) tick();
        st = 1'b1; av = 1'b1;
        tick();
        chk("abort_busy", 3, 16'(ob[3]), 16'd1);
        chk("abort_rep", 3, 16'(orc[3]), 16'd1);
        rn = 1'b0;
        tick();
        rn = 1'b1; st = 1'b0; av = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("abort_idle", k, 16'(ob[k]), 16'd0);
            chk("abort_rep0", k, 16'(orc[k]), 16'd0);
            chk("abort_nopulse", k, 16'({om[k], of[k]}), 16'd0);
        end
        tick();
        st = 1'b1; av = 1'b1;
        tick();
        tick();
        chk("busy_start_ignored", 0, 16'(orc[0]), 16'd2);
        st = 1'b0; av = 1'b0;
        tick();
        chk("busy_start_fail", 0, 16'(of[0]), 16'd1);
        tick();
        for (int i = 0; i < 3000; i++) begin
            rn = ($urandom_range(0, 99) != 0);
            st = ($urandom_range(0, 3) == 0);
            av = ($urandom_range(0, 9) < 7);
            bv = ($urandom_range(0, 3) == 0);
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sva_rep_matcher.md
SVA_REP_MATCHER -- requirements
Module: sva_rep_matcher

Interface
REQ-001 The module SHALL have parameter MIN_REP, default 0, minimum repetitions of a (range 0..15).
REQ-002 The module SHALL have parameter MAX_REP, default 3, maximum repetitions of a (range MIN_REP..15).
REQ-003 The module SHALL have parameter DELAY, default 1, cycle delay between the last a and b (legal values 0 or 1).
REQ-004 The module SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 The module SHALL have port rst_n  input  1  synchronous reset, active-low.
REQ-006 The module SHALL have port start  input  1  begins an attempt in this cycle (cycle 0).
REQ-007 The module SHALL have port a  input  1  repeated operand.
REQ-008 The module SHALL have port b  input  1  terminating operand.
REQ-009 The module SHALL have port match  output  1  one-cycle pulse: the attempt matched a[*MIN_REP:MAX_REP] ##DELAY b.
REQ-010 The module SHALL have port fail  output  1  one-cycle pulse: the attempt cannot match.
REQ-011 The module SHALL have port busy  output  1  an attempt is in progress past cycle 0.
REQ-012 The module SHALL have port rep_count  output  4  consecutive a-highs counted in the current attempt (n).

Function
REQ-013 States SHALL be IDLE and RUN; an attempt is evaluated in IDLE when start=1, and then in every RUN cycle.
REQ-014 Each evaluated cycle uses n = a-highs seen before this cycle in the attempt (n=0 in cycle 0).
REQ-015 When DELAY=1, the cycle SHALL be a match if b=1 and MIN_REP<=n<=MAX_REP; n=0 is the empty repetition, so with MIN_REP=0 b in cycle 0 matches.
REQ-016 When DELAY=1 and there is no match, the attempt SHALL continue with n+1 if a=1 and n+1<=MAX_REP; otherwise it SHALL be a fail.
REQ-017 When DELAY=0, the cycle SHALL be a match if a=1, b=1 and MIN_REP<=n+1<=MAX_REP; the empty repetition never matches.
REQ-018 When DELAY=0 and there is no match, the attempt SHALL continue if a=1 and n+1<MAX_REP; otherwise it SHALL be a fail. With MAX_REP=0 every attempt fails in cycle 0.
REQ-019 First match wins: a match SHALL end the attempt even if further repetitions could also match.
REQ-020 match/fail SHALL be registered: asserted for exactly one cycle, on the cycle after the deciding cycle; they SHALL never be asserted together.
REQ-021 The state SHALL be RUN after a cycle that continues; it SHALL return to IDLE after the deciding cycle; busy SHALL equal (state==RUN).
REQ-022 start while busy=1 SHALL be ignored (no overlapping attempts); start in the same cycle as a decision SHALL also be ignored.
REQ-023 rep_count SHALL show n for the current RUN cycle and SHALL hold its last value in IDLE until the next start.

Reset
REQ-024 When rst_n=0 at a posedge, the state SHALL become IDLE and match=0, fail=0, busy=0, rep_count=0; any attempt is abandoned with no match/fail pulse.
REQ-025 start asserted during reset SHALL be ignored.

Configuration
REQ-026 When SVA_REP_MATCHER_STATS_EN is defined, the module SHALL add outputs match_cnt[15:0] and fail_cnt[15:0], which count match/fail pulses, saturate at 16'hFFFF and clear on reset.
REQ-027 Without SVA_REP_MATCHER_STATS_EN, these ports and their logic SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-028 MIN=0,MAX=3,DELAY=1: start=1,b=1 in cycle 0 -> match=1 in cycle 1, busy stays 0 (empty-sequence match).
REQ-029 MIN=0,MAX=3,DELAY=0: start=1,a=0,b=1 -> fail=1 in cycle 1 (empty ##0 never matches).
REQ-030 MIN=2,MAX=3,DELAY=1: a=1 for cycles 0-1, b=1 in cycle 2 -> match in cycle 3, rep_count=2 in cycle 2.
REQ-031 MIN=1,MAX=2,DELAY=1: a=1 for cycles 0-2, b=0 throughout -> fail in cycle 3 (cycle 2 has n+1=3>MAX).
REQ-032 An attempt is in progress (busy=1, rep_count=1) and rst_n=0 for one cycle -> next cycle busy=0, rep_count=0, and no match/fail pulse; start pulses during busy produce no second result.
REQ-033 STATS_EN build: 3 matches and 2 fails -> match_cnt=3, fail_cnt=2; forced saturation at 16'hFFFF holds on a further match.
